mem_dump_checker: RTL and testbench
===================================

# mem_dump_checker

Synthesisable post-run memory checker for the SCC: when the core halts, it consumes a stream of expected (address, word) pairs. It reads each word back from data memory through a byte-wide read port, assembles it in the selected byte order, and compares it with the expected value. It reports pass/fail, mismatch count, and the first failing address and values, so the same self-check runs on silicon/FPGA as in simulation. It sits beside `instruction_and_data`, fed by `halt_f` and an expected-value ROM or loader.

## Interface
- `ADDR_W`, 16: byte-address width of data memory.
- `WORD_BYTES`, 4: bytes per compared word (1..8); word width `DW = 8*WORD_BYTES`.
- `RD_LAT`, 1: memory read latency in cycles (1..4).
- `CNT_W`, 16: width of check/fail counters.
- `STOP_ON_FAIL`, 0: 1 = end the run at the first mismatch.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; the rising edge is used (tie to `halt_f`).
- `big_endian`  in  1  1 = MSB at lowest address; sampled on the start edge.
- `exp_valid`  in  1  expected entry available.
- `exp_ready`  out  1  checker accepts entry.
- `exp_addr`  in  ADDR_W  expected word start byte address.
- `exp_data`  in  DW  expected word value.
- `exp_last`  in  1  final entry of stream.
- `mem_rd_en`  out  1  byte read strobe.
- `mem_rd_addr`  out  ADDR_W  byte read address.
- `mem_rd_data`  in  8  read byte, valid RD_LAT cycles after strobe.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until next run.
- `pass`  out  1  done with zero failures.
- `chk_cnt`  out  CNT_W  entries checked, saturating.
- `fail_cnt`  out  CNT_W  mismatches plus range errors, saturating.
- `range_err`  out  1  sticky: some entry exceeded memory.
- `first_fail_addr`  out  ADDR_W  address of first failure.
- `first_fail_got`  out  DW  assembled DUT word at first failure (0 for range error).
- `first_fail_exp`  out  DW  expected word at first failure.

## Operation
- FSM states: IDLE, FETCH, READ, WAIT, COMPARE, DONE.
- IDLE: `exp_ready`=0. A `start` rising edge clears all counters, `first_fail_*`, `range_err`, `done` and `pass`, latches `big_endian`, and enters FETCH.
- FETCH: `exp_ready`=1. On `exp_valid & exp_ready`, the checker captures addr, data and last.
  - If `exp_addr + WORD_BYTES - 1 > 2^ADDR_W - 1` (computed ADDR_W+1 wide, no wrap), the entry is a range error. No reads are issued, and the FSM goes directly to COMPARE with the failure forced.
  - Otherwise the FSM enters READ.
- READ: N=WORD_BYTES cycles with `mem_rd_en`=1 and `mem_rd_addr` = addr+k, k=0..N-1.
- WAIT: the FSM stays here until all N bytes are captured. Capture is tracked by a RD_LAT-deep valid shift register. Byte k lands in bits [DW-1-8k -: 8] when big-endian, [8k +: 8] when little-endian.
- COMPARE: one cycle.
  - `chk_cnt`+1.
  - On mismatch or range error: `fail_cnt`+1. If this is the first failure, load `first_fail_*`. Set `range_err` if applicable.
  - Next state is DONE if last, or if (failure and STOP_ON_FAIL). Otherwise FETCH.
- DONE: `done`=1, `busy`=0, `pass` = (`fail_cnt`==0). Results hold. A new `start` rising edge restarts the run.
- A `start` edge while busy is ignored. `start` held high after a run does not retrigger.
- Counters saturate at all-ones. `fail_cnt` never exceeds `chk_cnt`.
- Reset at any time: async to IDLE. All outputs read 0 and `exp_ready`/`mem_rd_en` deassert immediately. A partially assembled word is discarded.

## Timing
- Start edge detect: `start` is registered. FETCH begins the cycle after the first cycle in which `start`=1 with registered `start`=0.
- Per entry with `exp_valid` held high: 1 (FETCH) + N (READ) + RD_LAT (WAIT) + 1 (COMPARE) cycles. For N=4, RD_LAT=1 this is 7 cycles.
- A range-error entry takes 2 cycles (FETCH, COMPARE).
- `exp_valid` low in FETCH stalls with no timeout. The stream must not change while `exp_valid`=1 and `exp_ready`=0.
- `done`/`pass`/counters update at the clock edge ending COMPARE. `done` is visible the next cycle.
- `busy` = state not in {IDLE, DONE}.

## Test plan
- Single entry: memory bytes 0x100..0x103 = 12 34 56 78, expected (0x100, 0x12345678), `big_endian`=1, `exp_last`=1. Required: `pass`=1, `chk_cnt`=1, `fail_cnt`=0, `done` 7 cycles after handshake.
- Endianness: same memory with `big_endian`=0 and expected 0x78563412. Required: pass. With expected 0x12345678 instead: `fail_cnt`=1, `first_fail_got`=0x78563412.
- Multi-failure: 5 entries with failures at entries 2 and 4, STOP_ON_FAIL=0. Required: `chk_cnt`=5, `fail_cnt`=2, `first_fail_addr` = entry 2 address. With STOP_ON_FAIL=1: `chk_cnt`=2, `done` asserts after entry 2.
- Range: entry at addr 0xFFFE (WORD_BYTES=4). Required: no `mem_rd_en`, `range_err`=1, `fail_cnt`=1, `first_fail_got`=0. Entry at 0xFFFC is in range and reads normally.
- Stall/latency: RD_LAT=3, with `exp_valid` toggled randomly. Required: correct assembly, no read issued during a FETCH stall, and a second `start` pulse mid-run is ignored.
- Reset mid-READ: assert `rst`=0 during the second byte read. Required: outputs 0 immediately. After release and a new `start` edge, the run completes with `pass`=1 on clean data.

Source files
------------

// File: rtl/mem_dump_checker_if.sv
// Expected-entry stream plus byte-wide memory read port seen by mem_dump_checker.
interface mem_dump_checker_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DW     = 32
);
    logic              exp_valid;
    logic              exp_ready;
    logic [ADDR_W-1:0] exp_addr;
    logic [DW-1:0]     exp_data;
    logic              exp_last;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;

    // Environment side: expected-value source and data memory.
    modport master (
        output exp_valid, exp_addr, exp_data, exp_last, mem_rd_data,
        input  exp_ready, mem_rd_en, mem_rd_addr
    );

    // Checker side.
    modport slave (
        input  exp_valid, exp_addr, exp_data, exp_last, mem_rd_data,
        output exp_ready, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/mem_dump_checker.sv
// Post-run memory checker: reads each expected word back byte by byte, assembles it in the
// latched byte order and compares it, keeping pass/fail, counters and first-failure details.
module mem_dump_checker #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned WORD_BYTES   = 4,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned STOP_ON_FAIL = 0,
    localparam int unsigned DW          = 8 * WORD_BYTES
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_big_endian,
    mem_dump_checker_if.slave   io_bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [CNT_W-1:0]    o_chk_cnt,
    output logic [CNT_W-1:0]    o_fail_cnt,
    output logic                o_range_err,
    output logic [ADDR_W-1:0]   o_first_fail_addr,
    output logic [DW-1:0]       o_first_fail_got,
    output logic [DW-1:0]       o_first_fail_exp
);

    localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StRead, StWait, StCompare, StDone
    } state_e;

    state_e            r_state;
    logic              r_start;
    logic              r_big;
    logic [ADDR_W-1:0] r_addr;
    logic [DW-1:0]     r_exp;
    logic              r_last;
    logic              r_range;
    logic [DW-1:0]     r_word;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [IDX_W-1:0]  r_cap_idx;
    logic [RD_LAT-1:0] r_vld;
    logic              r_exp_ready;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_done;
    logic              r_pass;
    logic [CNT_W-1:0]  r_chk;
    logic [CNT_W-1:0]  r_fail;
    logic              r_rerr;
    logic [ADDR_W-1:0] r_ffa;
    logic [DW-1:0]     r_ffg;
    logic [DW-1:0]     r_ffe;

    logic              w_start_edge;
    logic [ADDR_W:0]   w_end;
    logic              w_range;
    logic              w_hs;
    logic              w_cap;
    logic [IDX_W-1:0]  w_byte_pos;
    logic              w_fail;

    assign w_start_edge = i_start & ~r_start;
    // One extra bit so an entry running past the top of memory is caught instead of wrapping.
    assign w_end        = {1'b0, io_bus.exp_addr} + (ADDR_W + 1)'(WORD_BYTES - 1);
    assign w_range      = w_end > {1'b0, {ADDR_W{1'b1}}};
    assign w_hs         = io_bus.exp_valid & r_exp_ready;
    assign w_cap        = r_vld[RD_LAT-1];
    assign w_byte_pos   = r_big ? (LAST_IDX - r_cap_idx) : r_cap_idx;
    assign w_fail       = r_range | (r_word != r_exp);

    assign io_bus.exp_ready   = r_exp_ready;
    assign io_bus.mem_rd_en   = r_rd_en;
    assign io_bus.mem_rd_addr = r_rd_addr;

    assign o_busy            = (r_state != StIdle) && (r_state != StDone);
    assign o_done            = r_done;
    assign o_pass            = r_pass;
    assign o_chk_cnt         = r_chk;
    assign o_fail_cnt        = r_fail;
    assign o_range_err       = r_rerr;
    assign o_first_fail_addr = r_ffa;
    assign o_first_fail_got  = r_ffg;
    assign o_first_fail_exp  = r_ffe;

    // Register start for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_start <= 1'b0;
        else        r_start <= i_start;
    end

    // Read-data valid pipeline: a strobe's byte is on mem_rd_data when it reaches the top bit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_vld <= '0;
        else        r_vld <= RD_LAT'({r_vld, r_rd_en});
    end

    // Main sequencer with registered handshake, read strobe and result outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= StIdle;
            r_big       <= 1'b0;
            r_addr      <= '0;
            r_exp       <= '0;
            r_last      <= 1'b0;
            r_range     <= 1'b0;
            r_word      <= '0;
            r_rd_idx    <= '0;
            r_cap_idx   <= '0;
            r_exp_ready <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_chk       <= '0;
            r_fail      <= '0;
            r_rerr      <= 1'b0;
            r_ffa       <= '0;
            r_ffg       <= '0;
            r_ffe       <= '0;
        end else begin
            if (w_cap) begin
                for (int k = 0; k < WORD_BYTES; k++) begin
                    if (w_byte_pos == IDX_W'(k)) r_word[8*k +: 8] <= io_bus.mem_rd_data;
                end
                r_cap_idx <= r_cap_idx + IDX_W'(1);
            end
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_start_edge) begin
                        r_state     <= StFetch;
                        r_exp_ready <= 1'b1;
                        r_big       <= i_big_endian;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_chk       <= '0;
                        r_fail      <= '0;
                        r_rerr      <= 1'b0;
                        r_ffa       <= '0;
                        r_ffg       <= '0;
                        r_ffe       <= '0;
                    end
                end
                StFetch: begin
                    if (w_hs) begin
                        r_exp_ready <= 1'b0;
                        r_addr      <= io_bus.exp_addr;
                        r_exp       <= io_bus.exp_data;
                        r_last      <= io_bus.exp_last;
                        r_range     <= w_range;
                        // Cleared so an out-of-range entry reports an all-zero word.
                        r_word      <= '0;
                        r_cap_idx   <= '0;
                        if (w_range) begin
                            r_state <= StCompare;
                        end else begin
                            r_state   <= StRead;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= io_bus.exp_addr;
                            r_rd_idx  <= '0;
                        end
                    end
                end
                StRead: begin
                    if (r_rd_idx == LAST_IDX) begin
                        r_rd_en <= 1'b0;
                        r_state <= StWait;
                    end else begin
                        r_rd_idx  <= r_rd_idx + IDX_W'(1);
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                StWait: begin
                    if (w_cap && (r_cap_idx == LAST_IDX)) r_state <= StCompare;
                end
                StCompare: begin
                    if (!(&r_chk)) r_chk <= r_chk + CNT_W'(1);
                    if (w_fail) begin
                        if (!(&r_fail)) r_fail <= r_fail + CNT_W'(1);
                        if (r_fail == '0) begin
                            r_ffa <= r_addr;
                            r_ffg <= r_word;
                            r_ffe <= r_exp;
                        end
                        if (r_range) r_rerr <= 1'b1;
                    end
                    if (r_last || (w_fail && (STOP_ON_FAIL != 0))) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_pass  <= !w_fail && (r_fail == '0);
                    end else begin
                        r_state     <= StFetch;
                        r_exp_ready <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_checker.sv
// Bench for mem_dump_checker: three instances (default, stop-on-fail, 3-cycle read latency),
// each with its own stream handshake and a latency-accurate byte memory model.
module tb_mem_dump_checker;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned WB     = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned NDUT   = 3;
    localparam int unsigned LAT_T [NDUT] = '{1, 1, 3};
    localparam int unsigned SOF_T [NDUT] = '{0, 1, 0};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NDUT-1:0]   start = '0;
    logic [NDUT-1:0]   valid = '0;
    logic              big = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DW-1:0]     e_data = '0;
    logic              e_last = 1'b0;

    logic [NDUT-1:0]   ready, rd_en, busy, done, pass, rerr;
    logic [ADDR_W-1:0] rd_addr [NDUT];
    logic [ADDR_W-1:0] ffa [NDUT];
    logic [DW-1:0]     ffg [NDUT];
    logic [DW-1:0]     ffe [NDUT];
    logic [CNT_W-1:0]  chk [NDUT];
    logic [CNT_W-1:0]  fcnt [NDUT];

    logic [7:0]        mem [65536];
    int                rd_cnt [NDUT];
    int                ovl_cnt [NDUT];
    int                total = 0;
    int                bad = 0;

    // Stream under test and reference-model results.
    logic [ADDR_W-1:0] q_a [$];
    logic [DW-1:0]     q_d [$];
    int                m_used, m_chk, m_fail, m_reads;
    bit                m_rerr;
    logic [ADDR_W-1:0] m_ffa;
    logic [DW-1:0]     m_ffg, m_ffe;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_dump_checker_if #(.ADDR_W(ADDR_W), .DW(DW)) u_if ();
        logic [7:0] pipe [4];

        assign u_if.exp_valid   = valid[g];
        assign u_if.exp_addr    = e_addr;
        assign u_if.exp_data    = e_data;
        assign u_if.exp_last    = e_last;
        assign u_if.mem_rd_data = pipe[LAT_T[g]-1];
        assign ready[g]         = u_if.exp_ready;
        assign rd_en[g]         = u_if.mem_rd_en;
        assign rd_addr[g]       = u_if.mem_rd_addr;

        always @(posedge clk) begin
            pipe[0] <= mem[u_if.mem_rd_addr];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        mem_dump_checker #(
            .ADDR_W      (ADDR_W),
            .WORD_BYTES  (WB),
            .RD_LAT      (LAT_T[g]),
            .CNT_W       (CNT_W),
            .STOP_ON_FAIL(SOF_T[g])
        ) u_dut (
            .i_clk            (clk),
            .i_rst            (rst_n),
            .i_start          (start[g]),
            .i_big_endian     (big),
            .io_bus           (u_if),
            .o_busy           (busy[g]),
            .o_done           (done[g]),
            .o_pass           (pass[g]),
            .o_chk_cnt        (chk[g]),
            .o_fail_cnt       (fcnt[g]),
            .o_range_err      (rerr[g]),
            .o_first_fail_addr(ffa[g]),
            .o_first_fail_got (ffg[g]),
            .o_first_fail_exp (ffe[g])
        );
    end

    // Count read strobes, and strobes issued while the stream handshake is open.
    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (rd_en[g]) rd_cnt[g] <= rd_cnt[g] + 1;
            if (rd_en[g] && ready[g]) ovl_cnt[g] <= ovl_cnt[g] + 1;
        end
    end

    function automatic bit in_range(int a);
        return (a + int'(WB) - 1) <= 65535;
    endfunction

    function automatic logic [DW-1:0] ref_word(int a, bit be);
        logic [DW-1:0] w = '0;
        for (int k = 0; k < int'(WB); k++) begin
            if (be) w = (w << 8) | DW'(mem[a+k]);
            else    w = w | (DW'(mem[a+k]) << (8 * k));
        end
        return w;
    endfunction

    task automatic run_model(int sel, bit be);
        logic [DW-1:0] got;
        bit rng, f;
        m_used = 0; m_chk = 0; m_fail = 0; m_reads = 0; m_rerr = 0;
        m_ffa = '0; m_ffg = '0; m_ffe = '0;
        for (int i = 0; i < q_a.size(); i++) begin
            m_used++;
            rng = !in_range(int'(q_a[i]));
            got = rng ? '0 : ref_word(int'(q_a[i]), be);
            f   = rng || (got !== q_d[i]);
            m_chk++;
            if (!rng) m_reads += WB;
            if (f) begin
                if (m_fail == 0) begin m_ffa = q_a[i]; m_ffg = got; m_ffe = q_d[i]; end
                m_fail++;
                if (rng) m_rerr = 1;
                if (SOF_T[sel] != 0) break;
            end
        end
    endtask

    task automatic build_stream(int n, bit be, int pct_bad, int pct_range);
        int a;
        logic [DW-1:0] d;
        q_a.delete(); q_d.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < pct_range) a = $urandom_range(16'hFFFD, 16'hFFFF);
            else a = $urandom_range(0, 16'hFFFC);
            d = in_range(a) ? ref_word(a, be) : DW'($urandom);
            if ($urandom_range(0, 99) < pct_bad) d = d ^ (DW'($urandom) | 32'h1);
            q_a.push_back(ADDR_W'(a));
            q_d.push_back(d);
        end
    endtask

    task automatic send_entry(int sel, logic [ADDR_W-1:0] a, logic [DW-1:0] d, bit last,
                              bit stall, output bit ok);
        ok = 0;
        @(negedge clk);
        if (stall) begin
            valid[sel] = 1'b0;
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        e_addr = a; e_data = d; e_last = last; valid[sel] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (ready[sel]) begin @(posedge clk); ok = 1; break; end
            @(negedge clk);
        end
        #1 valid[sel] = 1'b0;
    endtask

    // Start a run, feed the entries the model says get consumed, and score the results.
    task automatic run_stream(int sel, bit be, bit stall, bit mid_start, string tag);
        bit ok;
        int r0, o0;
        run_model(sel, be);
        r0 = rd_cnt[sel];
        o0 = ovl_cnt[sel];
        @(negedge clk); big = be; start[sel] = 1'b1;
        @(negedge clk); start[sel] = 1'b0;
        for (int i = 0; i < m_used; i++) begin
            if (mid_start && i == 2) begin
                @(negedge clk); start[sel] = 1'b1;
                @(negedge clk); start[sel] = 1'b0;
            end
            send_entry(sel, q_a[i], q_d[i], i == q_a.size() - 1, stall, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL %s.handshake dut=%0d entry=%0d got=timeout exp=accept", tag, sel, i); end
        end
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done[sel]) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s.done dut=%0d got=0 exp=1", tag, sel); end
        total++;
        if (pass[sel] !== (m_fail == 0) || busy[sel] !== 1'b0) begin
            bad++; $display("FAIL %s.pass_busy dut=%0d got=%b/%b exp=%b/0", tag, sel, pass[sel], busy[sel], m_fail == 0);
        end
        total++;
        if (chk[sel] !== CNT_W'(m_chk)) begin
            bad++; $display("FAIL %s.chk_cnt dut=%0d got=%0d exp=%0d", tag, sel, chk[sel], m_chk);
        end
        total++;
        if (fcnt[sel] !== CNT_W'(m_fail)) begin
            bad++; $display("FAIL %s.fail_cnt dut=%0d got=%0d exp=%0d", tag, sel, fcnt[sel], m_fail);
        end
        total++;
        if (rerr[sel] !== m_rerr) begin
            bad++; $display("FAIL %s.range_err dut=%0d got=%b exp=%b", tag, sel, rerr[sel], m_rerr);
        end
        total++;
        if (ffa[sel] !== m_ffa || ffg[sel] !== m_ffg || ffe[sel] !== m_ffe) begin
            bad++; $display("FAIL %s.first_fail dut=%0d got=%h/%h/%h exp=%h/%h/%h", tag, sel,
                            ffa[sel], ffg[sel], ffe[sel], m_ffa, m_ffg, m_ffe);
        end
        total++;
        if (rd_cnt[sel] - r0 !== m_reads || ovl_cnt[sel] - o0 !== 0) begin
            bad++; $display("FAIL %s.reads dut=%0d got=%0d/%0d exp=%0d/0", tag, sel,
                            rd_cnt[sel] - r0, ovl_cnt[sel] - o0, m_reads);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            total++;
            if ({ready[g], rd_en[g], busy[g], done[g], pass[g], rerr[g]} !== 6'b0) begin
                bad++; $display("FAIL reset.flags dut=%0d got=%b exp=000000", g,
                                {ready[g], rd_en[g], busy[g], done[g], pass[g], rerr[g]});
            end
            total++;
            if (chk[g] !== '0 || fcnt[g] !== '0) begin
                bad++; $display("FAIL reset.counts dut=%0d got=%0d/%0d exp=0/0", g, chk[g], fcnt[g]);
            end
            total++;
            if (ffa[g] !== '0 || ffg[g] !== '0 || ffe[g] !== '0) begin
                bad++; $display("FAIL reset.first_fail dut=%0d got=%h/%h/%h exp=0", g, ffa[g], ffg[g], ffe[g]);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Valid is already high, so the entry is accepted in the first FETCH cycle and the run
    // takes FETCH + 4 READ + 1 WAIT + COMPARE = 7 cycles from the start edge to done.
    task automatic test_single();
        int cyc = 0;
        mem[16'h0100] = 8'h12; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h56; mem[16'h0103] = 8'h78;
        @(negedge clk);
        big = 1'b1; e_addr = 16'h0100; e_data = 32'h12345678; e_last = 1'b1; valid[0] = 1'b1;
        start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        while (!done[0] && cyc < 50) begin @(posedge clk); cyc++; #1; end
        valid[0] = 1'b0;
        total++;
        if (cyc !== 7) begin bad++; $display("FAIL single.latency got=%0d exp=7", cyc); end
        total++;
        if (pass[0] !== 1'b1 || chk[0] !== 16'd1 || fcnt[0] !== 16'd0) begin
            bad++; $display("FAIL single.result got=%b/%0d/%0d exp=1/1/0", pass[0], chk[0], fcnt[0]);
        end
    endtask

    task automatic test_endian();
        q_a.delete(); q_d.delete();
        q_a.push_back(16'h0100); q_d.push_back(32'h78563412);
        run_stream(0, 1'b0, 1'b0, 1'b0, "endian_le_ok");
        total++;
        if (pass[0] !== 1'b1) begin bad++; $display("FAIL endian.le_pass got=%b exp=1", pass[0]); end
        q_d[0] = 32'h12345678;
        run_stream(0, 1'b0, 1'b0, 1'b0, "endian_le_bad");
        total++;
        if (fcnt[0] !== 16'd1 || ffg[0] !== 32'h78563412) begin
            bad++; $display("FAIL endian.le_bad got=%0d/%h exp=1/78563412", fcnt[0], ffg[0]);
        end
    endtask

    task automatic test_multi();
        bit be = 1'($urandom);
        build_stream(5, be, 0, 0);
        q_d[1] = q_d[1] ^ (DW'($urandom) | 32'h1);
        q_d[3] = q_d[3] ^ (DW'($urandom) | 32'h100);
        run_stream(0, be, 1'b0, 1'b0, "multi");
        total++;
        if (chk[0] !== 16'd5 || fcnt[0] !== 16'd2 || ffa[0] !== q_a[1]) begin
            bad++; $display("FAIL multi.summary got=%0d/%0d/%h exp=5/2/%h", chk[0], fcnt[0], ffa[0], q_a[1]);
        end
        run_stream(1, be, 1'b0, 1'b0, "multi_stop");
        total++;
        if (chk[1] !== 16'd2 || fcnt[1] !== 16'd1 || done[1] !== 1'b1) begin
            bad++; $display("FAIL multi_stop.summary got=%0d/%0d/%b exp=2/1/1", chk[1], fcnt[1], done[1]);
        end
    endtask

    task automatic test_range();
        int r0;
        q_a.delete(); q_d.delete();
        q_a.push_back(16'hFFFE); q_d.push_back(DW'($urandom));
        r0 = rd_cnt[0];
        run_stream(0, 1'b1, 1'b0, 1'b0, "range_bad");
        total++;
        if (rerr[0] !== 1'b1 || fcnt[0] !== 16'd1 || ffg[0] !== '0 || rd_cnt[0] !== r0) begin
            bad++; $display("FAIL range.bad got=%b/%0d/%h/%0d exp=1/1/0/0", rerr[0], fcnt[0], ffg[0], rd_cnt[0] - r0);
        end
        q_a[0] = 16'hFFFC; q_d[0] = ref_word(16'hFFFC, 1'b1);
        r0 = rd_cnt[0];
        run_stream(0, 1'b1, 1'b0, 1'b0, "range_top_ok");
        total++;
        if (pass[0] !== 1'b1 || rerr[0] !== 1'b0 || rd_cnt[0] - r0 !== 4) begin
            bad++; $display("FAIL range.top_ok got=%b/%b/%0d exp=1/0/4", pass[0], rerr[0], rd_cnt[0] - r0);
        end
    endtask

    task automatic test_stall();
        for (int it = 0; it < 2; it++) begin
            bit be = 1'($urandom);
            build_stream(6, be, 30, 0);
            run_stream(2, be, 1'b1, 1'b1, "stall_lat3");
        end
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        q_a.delete(); q_d.delete();
        q_a.push_back(16'h0200); q_d.push_back(ref_word(16'h0200, 1'b1));
        q_a.push_back(16'h0300); q_d.push_back(ref_word(16'h0300, 1'b1));
        @(negedge clk); big = 1'b1; start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        send_entry(0, q_a[0], q_d[0], 1'b0, 1'b0, ok);
        @(negedge clk);
        e_addr = q_a[1]; e_data = q_d[1]; e_last = 1'b1; valid[0] = 1'b1;
        found = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (rd_en[0] && rd_addr[0] == 16'h0301) begin found = 1; break; end
        end
        total++;
        if (!found || !ok || chk[0] !== 16'd1) begin
            bad++; $display("FAIL rst_mid.reach got=%b/%b/%0d exp=1/1/1", found, ok, chk[0]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready[0], rd_en[0], busy[0], done[0], pass[0], rerr[0]} !== 6'b0 || chk[0] !== '0
            || rd_addr[0] !== '0) begin
            bad++; $display("FAIL rst_mid.outputs got=%b/%0d/%h exp=000000/0/0",
                            {ready[0], rd_en[0], busy[0], done[0], pass[0], rerr[0]}, chk[0], rd_addr[0]);
        end
        valid[0] = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_stream(0, 1'b1, 1'b0, 1'b0, "rst_mid_rerun");
        total++;
        if (pass[0] !== 1'b1) begin bad++; $display("FAIL rst_mid.pass got=%b exp=1", pass[0]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            bit be = 1'($urandom);
            int sel = (it == 3) ? 1 : 0;
            build_stream($urandom_range(3, 7), be, 25, 15);
            run_stream(sel, be, 1'($urandom), 1'b0, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_single();
        test_endian();
        test_multi();
        test_range();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
